// File: rtl/axi4_master_wr_arbiter.sv
// rtl/axi4_master_wr_arbiter.sv - round-robin sharing of one AXI4 write port among NUM_REQ requesters
// Ports:
//   aclk, areset                   clock, synchronous active-high reset
//   req_aw* / req_w* / req_b*      packed per-requester AW, W and B channels (requester i at slice i)
//   m_aw* / m_w* / m_b*            single master-side write port toward the interconnect
//   busy                           AW grant pending or W bursts still owed
//   err_bid_unmapped               one-cycle pulse after a B handshake whose index has no requester
module axi4_master_wr_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int IDX_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [NUM_REQ-1:0]                 req_awvalid,
  output logic [NUM_REQ-1:0]                 req_awready,
  input  logic [NUM_REQ*ID_WIDTH-1:0]        req_awid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_awaddr,
  input  logic [NUM_REQ*8-1:0]               req_awlen,
  input  logic [NUM_REQ*3-1:0]               req_awsize,
  input  logic [NUM_REQ*2-1:0]               req_awburst,
  input  logic [NUM_REQ-1:0]                 req_wvalid,
  output logic [NUM_REQ-1:0]                 req_wready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb,
  input  logic [NUM_REQ-1:0]                 req_wlast,
  output logic [NUM_REQ-1:0]                 req_bvalid,
  input  logic [NUM_REQ-1:0]                 req_bready,
  output logic [ID_WIDTH-1:0]                req_bid,
  output logic [1:0]                         req_bresp,
  output logic [ID_WIDTH+IDX_W-1:0]          m_awid,
  output logic [ADDR_WIDTH-1:0]              m_awaddr,
  output logic [7:0]                         m_awlen,
  output logic [2:0]                         m_awsize,
  output logic [1:0]                         m_awburst,
  output logic                               m_awvalid,
  input  logic                               m_awready,
  output logic [DATA_WIDTH-1:0]              m_wdata,
  output logic [DATA_WIDTH/8-1:0]            m_wstrb,
  output logic                               m_wlast,
  output logic                               m_wvalid,
  input  logic                               m_wready,
  input  logic [ID_WIDTH+IDX_W-1:0]          m_bid,
  input  logic [1:0]                         m_bresp,
  input  logic                               m_bvalid,
  output logic                               m_bready,
  output logic                               busy,
  output logic                               err_bid_unmapped
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0] r_last_grant, w_last_grant_nxt;
  logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic             w_push, w_pop, w_fifo_empty, w_fifo_full;
  logic [IDX_W-1:0] w_head;
  logic [IDX_W:0]   w_rr;
  logic [IDX_W-1:0] w_bidx;
  logic             w_unmapped;

  // Returns {found, index}: first set bit of valid, searching upward from last+1 and wrapping.
  // Offsets are scanned from farthest to nearest so the nearest hit is the one kept.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] result;
    int             cand;
    result = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last) + off) % NUM_REQ;
      if (valid[cand[IDX_W-1:0]]) result = {1'b1, cand[IDX_W-1:0]};
    end
    return result;
  endfunction

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_FULL);
  assign w_head       = r_fifo[r_rptr];
  assign busy         = (r_state == ST_GRANT) || !w_fifo_empty;

  // AW FSM next-state
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_push           = 1'b0;
    w_rr             = rr_pick(req_awvalid, r_last_grant);
    case (r_state)
      ST_IDLE: begin
        if (w_rr[IDX_W] && !w_fifo_full) begin
          w_grant_nxt = w_rr[IDX_W-1:0];
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (m_awvalid && m_awready) begin
          w_push           = 1'b1;
          w_last_grant_nxt = r_grant;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // AW mux on the registered grant
  always_comb begin
    m_awvalid   = 1'b0;
    req_awready = '0;
    m_awid      = '0;
    m_awaddr    = '0;
    m_awlen     = '0;
    m_awsize    = '0;
    m_awburst   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == IDX_W'(i)) begin
        m_awid    = {r_grant, req_awid[i*ID_WIDTH +: ID_WIDTH]};
        m_awaddr  = req_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        m_awlen   = req_awlen[i*8 +: 8];
        m_awsize  = req_awsize[i*3 +: 3];
        m_awburst = req_awburst[i*2 +: 2];
        if (r_state == ST_GRANT) begin
          m_awvalid      = req_awvalid[i];
          req_awready[i] = m_awready;
        end
      end
    end
  end

  // W mux follows the order-FIFO head; only wlast retires a burst
  always_comb begin
    m_wvalid   = 1'b0;
    req_wready = '0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wlast    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_head == IDX_W'(i)) begin
        m_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_wstrb = req_wstrb[i*STRB_W +: STRB_W];
        m_wlast = req_wlast[i];
        if (!w_fifo_empty) begin
          m_wvalid      = req_wvalid[i];
          req_wready[i] = m_wready;
        end
      end
    end
  end

  assign w_pop = m_wvalid && m_wready && m_wlast;

  // B demux by the index bits prepended to the ID; unmapped indices are drained
  assign w_bidx     = m_bid[ID_WIDTH+IDX_W-1 -: IDX_W];
  assign w_unmapped = ({1'b0, w_bidx} >= NUM_REQ_W);
  assign req_bid    = m_bid[ID_WIDTH-1:0];
  assign req_bresp  = m_bresp;

  always_comb begin
    req_bvalid = '0;
    m_bready   = w_unmapped;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_bidx == IDX_W'(i)) begin
        req_bvalid[i] = m_bvalid;
        m_bready      = req_bready[i];
      end
    end
  end

  assign err_bid_unmapped = r_err;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_err        <= m_bvalid && w_unmapped;
      if (w_push) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by r_count
  always_ff @(posedge aclk) begin
    if (w_push) r_fifo[r_wptr] <= r_grant;
  end

endmodule

// File: tb/tb_axi4_master_wr_arbiter.sv
// tb/tb_axi4_master_wr_arbiter.sv - self-checking bench for axi4_master_wr_arbiter
module tb_axi4_master_wr_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic [1:0]  req_awvalid, req_awready;
  logic [7:0]  req_awid;
  logic [63:0] req_awaddr;
  logic [15:0] req_awlen;
  logic [5:0]  req_awsize;
  logic [3:0]  req_awburst;
  logic [1:0]  req_wvalid, req_wready;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic [1:0]  req_wlast, req_bvalid, req_bready;
  logic [3:0]  req_bid;
  logic [1:0]  req_bresp;
  logic [4:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [4:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready, busy, err_bid_unmapped;

  // three-requester instance, used for the unmapped-index B path
  logic [2:0]  b3_bvalid, b3_bready, d3_awready, d3_wready;
  logic [3:0]  b3_bid, d3_wstrb;
  logic [1:0]  b3_bresp, d3_awburst;
  logic [5:0]  b3_m_bid, d3_awid;
  logic        b3_m_bvalid, b3_m_bready, b3_err;
  logic [31:0] d3_awaddr, d3_wdata;
  logic [7:0]  d3_awlen;
  logic [2:0]  d3_awsize;
  logic        d3_awvalid, d3_wvalid, d3_wlast, d3_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // traffic model state
  int          nb[2], nbeat[2], aw_i[2], w_i[2], start_cyc[2];
  logic [31:0] b_addr[2][8];
  logic [7:0]  b_len[2][8];
  logic [3:0]  b_id[2][8];
  int          b_beat0[2][8];
  logic [31:0] wd[2][32];
  logic        wl[2][32];
  int          exp_q[$];

  always #5 aclk = ~aclk;

  axi4_master_wr_arbiter #(.NUM_REQ(2)) u_dut (
    .aclk(aclk), .areset(areset),
    .req_awvalid(req_awvalid), .req_awready(req_awready), .req_awid(req_awid),
    .req_awaddr(req_awaddr), .req_awlen(req_awlen), .req_awsize(req_awsize),
    .req_awburst(req_awburst), .req_wvalid(req_wvalid), .req_wready(req_wready),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_wlast(req_wlast),
    .req_bvalid(req_bvalid), .req_bready(req_bready), .req_bid(req_bid), .req_bresp(req_bresp),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .busy(busy), .err_bid_unmapped(err_bid_unmapped)
  );

  axi4_master_wr_arbiter #(.NUM_REQ(3)) u_dut3 (
    .aclk(aclk), .areset(areset),
    .req_awvalid(3'b000), .req_awready(d3_awready), .req_awid(12'h0),
    .req_awaddr(96'h0), .req_awlen(24'h0), .req_awsize(9'h0),
    .req_awburst(6'h0), .req_wvalid(3'b000), .req_wready(d3_wready),
    .req_wdata(96'h0), .req_wstrb(12'h0), .req_wlast(3'b000),
    .req_bvalid(b3_bvalid), .req_bready(b3_bready), .req_bid(b3_bid), .req_bresp(b3_bresp),
    .m_awid(d3_awid), .m_awaddr(d3_awaddr), .m_awlen(d3_awlen), .m_awsize(d3_awsize),
    .m_awburst(d3_awburst), .m_awvalid(d3_awvalid), .m_awready(1'b0),
    .m_wdata(d3_wdata), .m_wstrb(d3_wstrb), .m_wlast(d3_wlast), .m_wvalid(d3_wvalid),
    .m_wready(1'b0), .m_bid(b3_m_bid), .m_bresp(2'b01), .m_bvalid(b3_m_bvalid),
    .m_bready(b3_m_bready), .busy(d3_busy), .err_bid_unmapped(b3_err)
  );

  task automatic clear_inputs();
    req_awvalid = '0; req_awid = '0; req_awaddr = '0; req_awlen = '0;
    req_awsize = '0; req_awburst = '0; req_wvalid = '0; req_wdata = '0;
    req_wstrb = '0; req_wlast = '0; req_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
    b3_bready = '0; b3_m_bid = '0; b3_m_bvalid = 1'b0;
  endtask

  // ends #1 after the last reset edge with areset already released
  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic clear_traffic();
    for (int r = 0; r < 2; r++) begin
      nb[r] = 0; nbeat[r] = 0; aw_i[r] = 0; w_i[r] = 0; start_cyc[r] = 0;
    end
    exp_q.delete();
  endtask

  task automatic add_burst(input int r, input int len);
    b_addr[r][nb[r]]  = $urandom;
    b_id[r][nb[r]]    = 4'($urandom);
    b_len[r][nb[r]]   = 8'(len);
    b_beat0[r][nb[r]] = nbeat[r];
    for (int j = 0; j <= len; j++) begin
      wd[r][nbeat[r]] = $urandom;
      wl[r][nbeat[r]] = (j == len);
      nbeat[r]++;
    end
    nb[r]++;
  endtask

  // Requester/slave traffic engine. Expected grant order follows round-robin over the
  // requesters that still have AWs pending; expected W beats are the grant-ordered bursts.
  task automatic run_traffic(input int max_cyc, input bit rnd);
    int          last_g, g, eg, e, er, ek;
    logic [1:0]  pend, exp_wr;
    logic [1:0]  exp_bv;
    bit          done;
    last_g = 1;
    done   = 1'b0;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        req_awvalid[r]          = (aw_i[r] < nb[r]) && (cyc >= start_cyc[r]);
        req_awid[r*4 +: 4]      = b_id[r][aw_i[r]];
        req_awaddr[r*32 +: 32]  = b_addr[r][aw_i[r]];
        req_awlen[r*8 +: 8]     = b_len[r][aw_i[r]];
        req_awsize[r*3 +: 3]    = 3'd2;
        req_awburst[r*2 +: 2]   = 2'b01;
        req_wvalid[r]           = (w_i[r] < nbeat[r]) && (!rnd || $urandom_range(0, 3) != 0);
        req_wdata[r*32 +: 32]   = wd[r][w_i[r]];
        req_wstrb[r*4 +: 4]     = wd[r][w_i[r]][3:0];
        req_wlast[r]            = wl[r][w_i[r]];
      end
      m_awready = !rnd || ($urandom_range(0, 3) != 0);
      m_wready  = !rnd || ($urandom_range(0, 3) != 0);
      if (rnd) begin
        m_bvalid   = 1'($urandom);
        m_bid      = 5'($urandom);
        m_bresp    = 2'($urandom);
        req_bready = 2'($urandom);
      end
      @(negedge aclk);
      if (rnd) begin
        exp_bv = '0;
        if (m_bvalid) exp_bv[m_bid[4]] = 1'b1;
        n_checks += 3;
        if (req_bvalid !== exp_bv) begin
          n_fail++; $display("FAIL rnd_bvalid: got %b expected %b", req_bvalid, exp_bv);
        end
        if (m_bready !== req_bready[m_bid[4]]) begin
          n_fail++; $display("FAIL rnd_bready: got %b expected %b", m_bready, req_bready[m_bid[4]]);
        end
        if ({req_bid, req_bresp} !== {m_bid[3:0], m_bresp}) begin
          n_fail++; $display("FAIL rnd_bid: got %h/%h expected %h/%h", req_bid, req_bresp, m_bid[3:0], m_bresp);
        end
      end
      exp_wr = '0;
      if (exp_q.size() != 0 && m_wready) exp_wr[exp_q[0] / 64] = 1'b1;
      n_checks += 2;
      if (req_wready !== exp_wr) begin
        n_fail++; $display("FAIL w_ready: cyc %0d got %b expected %b", cyc, req_wready, exp_wr);
      end
      if (m_wvalid !== (exp_q.size() != 0 && req_wvalid[exp_q.size() != 0 ? exp_q[0] / 64 : 0])) begin
        n_fail++; $display("FAIL w_valid: cyc %0d got %b", cyc, m_wvalid);
      end
      if (m_wvalid && m_wready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL w_unexpected: beat %h with no granted burst", m_wdata);
        end else begin
          e = exp_q.pop_front(); er = e / 64; ek = e % 64;
          if ({m_wdata, m_wstrb, m_wlast} !== {wd[er][ek], wd[er][ek][3:0], wl[er][ek]}) begin
            n_fail++;
            $display("FAIL w_beat: got %h/%h/%b expected %h/%h/%b (req %0d beat %0d)",
                     m_wdata, m_wstrb, m_wlast, wd[er][ek], wd[er][ek][3:0], wl[er][ek], er, ek);
          end
        end
      end
      if (m_awvalid && m_awready) begin
        pend = req_awvalid;
        eg   = pend[(last_g + 1) % 2] ? (last_g + 1) % 2 : last_g;
        g    = int'(m_awid[4]);
        n_checks += 2;
        if (g != eg) begin
          n_fail++; $display("FAIL aw_grant: cyc %0d got %0d expected %0d", cyc, g, eg);
        end
        if ({m_awid[3:0], m_awaddr, m_awlen, m_awsize, m_awburst} !==
            {b_id[g][aw_i[g]], b_addr[g][aw_i[g]], b_len[g][aw_i[g]], 3'd2, 2'b01}) begin
          n_fail++; $display("FAIL aw_fields: got %h %h %h expected %h %h %h", m_awid[3:0], m_awaddr,
                             m_awlen, b_id[g][aw_i[g]], b_addr[g][aw_i[g]], b_len[g][aw_i[g]]);
        end
        for (int k = 0; k <= int'(b_len[g][aw_i[g]]); k++) exp_q.push_back(g * 64 + b_beat0[g][aw_i[g]] + k);
        last_g = g;
      end
      for (int r = 0; r < 2; r++) begin
        if (req_awvalid[r] && req_awready[r]) aw_i[r]++;
        if (req_wvalid[r] && req_wready[r])   w_i[r]++;
      end
      done = (aw_i[0] == nb[0]) && (aw_i[1] == nb[1]) && (w_i[0] == nbeat[0]) && (w_i[1] == nbeat[1]);
      @(posedge aclk); #1;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL traffic_timeout: aw %0d/%0d w %0d/%0d", aw_i[0], aw_i[1], w_i[0], w_i[1]);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    areset = 1'b1;
    req_awvalid = 2'b11;
    req_awid = {4'h5, 4'hA};
    repeat (2) @(posedge aclk);
    #1;
    n_checks++;
    if ({m_awvalid, m_wvalid, req_awready, req_wready, req_bvalid, busy, err_bid_unmapped, b3_err} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0",
               {m_awvalid, m_wvalid, req_awready, req_wready, req_bvalid, busy, err_bid_unmapped, b3_err});
    end
    areset = 1'b0;
    @(posedge aclk); #1;
    n_checks += 2;
    if (m_awvalid !== 1'b1 || m_awid !== 5'h0A) begin
      n_fail++; $display("FAIL reset_first_grant: got v=%b id=%h expected v=1 id=0a", m_awvalid, m_awid);
    end
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 1", busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_awvalid = 2'b11; req_awid = {4'h5, 4'hA};
    req_wvalid = 2'b11; req_wlast = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge aclk); #1;
      n_checks++;
      if (m_awvalid !== (k % 2 == 0)) begin
        n_fail++; $display("FAIL rr_bubble: step %0d got %b expected %b", k, m_awvalid, (k % 2 == 0));
      end
      if (k % 2 == 0) begin
        n_checks++;
        if (m_awid[4] !== 1'((k / 2) % 2)) begin
          n_fail++; $display("FAIL rr_grant: step %0d got %0d expected %0d", k, m_awid[4], (k / 2) % 2);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_w_order();
    do_reset();
    clear_traffic();
    add_burst(1, 3);
    add_burst(0, 0);
    start_cyc[0] = 2;
    run_traffic(60, 1'b0);
  endtask

  task automatic test_fifo_full();
    int hs;
    do_reset();
    hs = 0;
    req_awvalid = 2'b01; req_awid = 8'h03; m_awready = 1'b1; m_wready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge aclk);
      if (m_awvalid && m_awready) hs++;
      @(posedge aclk); #1;
    end
    n_checks += 2;
    if (hs != 4) begin
      n_fail++; $display("FAIL full_accepts: got %0d expected 4", hs);
    end
    if ({m_awvalid, req_awready, busy} !== 4'b0001) begin
      n_fail++; $display("FAIL full_stall: got v=%b rdy=%b busy=%b expected 0 00 1", m_awvalid, req_awready, busy);
    end
    req_wvalid = 2'b01; req_wlast = 2'b01; m_wready = 1'b1;
    @(posedge aclk); #1;
    req_wvalid = 2'b00; m_wready = 1'b0;
    n_checks++;
    if (m_awvalid !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_same: got %b expected 0", m_awvalid);
    end
    @(posedge aclk); #1;
    n_checks++;
    if (m_awvalid !== 1'b1) begin
      n_fail++; $display("FAIL full_resume: got %b expected 1", m_awvalid);
    end
    clear_inputs();
  endtask

  task automatic test_b_demux();
    m_bid = 5'b1_0011; m_bresp = 2'b10; m_bvalid = 1'b1; req_bready = 2'b00;
    #1;
    n_checks++;
    if ({req_bvalid, req_bid, req_bresp, m_bready} !== {2'b10, 4'h3, 2'b10, 1'b0}) begin
      n_fail++; $display("FAIL b_demux: got bv=%b bid=%h br=%b mr=%b expected 10 3 10 0",
                         req_bvalid, req_bid, req_bresp, m_bready);
    end
    req_bready = 2'b10;
    #1;
    n_checks++;
    if (m_bready !== 1'b1) begin
      n_fail++; $display("FAIL b_ready: got %b expected 1", m_bready);
    end
    @(posedge aclk); #1;
    m_bvalid = 1'b0;
    n_checks++;
    if (err_bid_unmapped !== 1'b0) begin
      n_fail++; $display("FAIL b_no_err: got %b expected 0", err_bid_unmapped);
    end
    clear_inputs();
  endtask

  task automatic test_unmapped_b();
    b3_m_bid = {2'd3, 4'h7}; b3_m_bvalid = 1'b1; b3_bready = 3'b000;
    #1;
    n_checks++;
    if ({b3_m_bready, b3_bvalid, b3_err} !== 5'b1_000_0) begin
      n_fail++; $display("FAIL unmapped_drain: got mr=%b bv=%b err=%b expected 1 000 0", b3_m_bready, b3_bvalid, b3_err);
    end
    @(posedge aclk); #1;
    b3_m_bvalid = 1'b0;
    n_checks++;
    if (b3_err !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_pulse: got %b expected 1", b3_err);
    end
    @(posedge aclk); #1;
    n_checks++;
    if (b3_err !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_pulse_end: got %b expected 0", b3_err);
    end
    b3_m_bid = {2'd2, 4'h1}; b3_m_bvalid = 1'b1;
    #1;
    n_checks++;
    if ({b3_bvalid, b3_m_bready} !== 4'b100_0) begin
      n_fail++; $display("FAIL mapped_idx2: got bv=%b mr=%b expected 100 0", b3_bvalid, b3_m_bready);
    end
    @(posedge aclk); #1;
    b3_m_bvalid = 1'b0;
    n_checks++;
    if (b3_err !== 1'b0) begin
      n_fail++; $display("FAIL mapped_no_err: got %b expected 0", b3_err);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    clear_traffic();
    for (int i = 0; i < 6; i++) begin
      add_burst(0, $urandom_range(0, 3));
      add_burst(1, $urandom_range(0, 3));
    end
    run_traffic(2000, 1'b1);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_w_order();
    test_fifo_full();
    test_b_demux();
    test_unmapped_b();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
